// File: rtl/square_wave_meas.sv
// Square-wave measurement: hysteresis edge detection, then period, high time and min/max per cycle.
// Define SQW_MEAS_FREQ_EST_EN to build the freq_ctrl estimator on freq_est (tied to 0 otherwise).
module square_wave_meas #(
    parameter logic [7:0]       TH_HI   = 8'd192,
    parameter logic [7:0]       TH_LO   = 8'd160,
    parameter int               CNT_W   = 24,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(24'hFF_FFFF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       sample_in,
    input  logic             sample_vld,
    input  logic             meas_clr,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic [7:0]       max_out,
    output logic [7:0]       min_out,
    output logic             meas_vld,
    output logic             timeout,
    output logic [7:0]       freq_est
);
    typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, ecnt_q, ecnt_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic [7:0]       rmax_q, rmax_d, rmin_q, rmin_d, max_q, max_d, min_q, min_d;
    logic             vld_q, vld_d, to_q, to_d;
    logic             is_hi, is_lo, arm, rise, fall, to_hit;
    logic [CNT_W-1:0] cnt_inc, ecnt_inc;
    logic [7:0]       smax, smin;

    assign is_hi    = sample_in >= TH_HI;
    assign is_lo    = sample_in <= TH_LO;
    // Both counters saturate rather than wrap.
    assign cnt_inc  = (&cnt_q)  ? cnt_q  : cnt_q  + CNT_W'(1);
    assign ecnt_inc = (&ecnt_q) ? ecnt_q : ecnt_q + CNT_W'(1);
    assign smax     = (sample_in > rmax_q) ? sample_in : rmax_q;
    assign smin     = (sample_in < rmin_q) ? sample_in : rmin_q;

    assign arm    = sample_vld && (state_q == IDLE) && is_lo;
    assign rise   = sample_vld && (state_q == ARMED || state_q == LOW) && is_hi;
    assign fall   = sample_vld && (state_q == HIGH) && is_lo;
    // ecnt counts valid samples since the last edge (or since arming).
    assign to_hit = sample_vld && (state_q != IDLE) && !rise && !fall && (ecnt_inc >= TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (meas_clr)    state_d = IDLE;
        else if (to_hit) state_d = IDLE;
        else if (arm)    state_d = ARMED;
        else if (rise)   state_d = HIGH;
        else if (fall)   state_d = LOW;
    end

    always_comb begin
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        ecnt_d   = ecnt_q;
        rmax_d   = rmax_q;
        rmin_d   = rmin_q;
        period_d = period_q;
        high_d   = high_q;
        max_d    = max_q;
        min_d    = min_q;
        vld_d    = 1'b0;
        to_d     = to_q;
        if (meas_clr) begin
            cnt_d    = '0;
            hcnt_d   = '0;
            ecnt_d   = '0;
            rmax_d   = '0;
            rmin_d   = 8'hFF;
            period_d = '0;
            high_d   = '0;
            max_d    = '0;
            min_d    = 8'hFF;
            to_d     = 1'b0;
        end else if (to_hit) begin
            cnt_d  = '0;
            hcnt_d = '0;
            ecnt_d = '0;
            to_d   = 1'b1;
        end else if (sample_vld && state_q != IDLE) begin
            cnt_d  = cnt_inc;
            ecnt_d = ecnt_inc;
            rmax_d = smax;
            rmin_d = smin;
            if (rise) begin
                // Publish only on a second rising edge; the rising sample opens the next period.
                if (state_q == LOW) begin
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    max_d    = rmax_q;
                    min_d    = rmin_q;
                    vld_d    = 1'b1;
                end
                cnt_d  = CNT_W'(1);
                ecnt_d = '0;
                rmax_d = sample_in;
                rmin_d = sample_in;
            end else if (fall) begin
                hcnt_d = cnt_q;
                ecnt_d = '0;
            end
        end else if (arm) begin
            ecnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            hcnt_q   <= '0;
            ecnt_q   <= '0;
            rmax_q   <= '0;
            rmin_q   <= 8'hFF;
            period_q <= '0;
            high_q   <= '0;
            max_q    <= '0;
            min_q    <= 8'hFF;
            vld_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            ecnt_q   <= ecnt_d;
            rmax_q   <= rmax_d;
            rmin_q   <= rmin_d;
            period_q <= period_d;
            high_q   <= high_d;
            max_q    <= max_d;
            min_q    <= min_d;
            vld_q    <= vld_d;
            to_q     <= to_d;
        end
    end

`ifdef SQW_MEAS_FREQ_EST_EN
    // Generator high time is freq_ctrl*1024+1 samples.
    logic [CNT_W-1:0] hm1, hsh;
    logic [7:0]       freq_q, freq_d;

    assign hm1 = hcnt_q - CNT_W'(1);
    assign hsh = hm1 >> 10;

    always_comb begin
        freq_d = freq_q;
        if (meas_clr)   freq_d = '0;
        else if (vld_d) freq_d = (hsh > CNT_W'(255)) ? 8'hFF : hsh[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) freq_q <= '0;
        else        freq_q <= freq_d;
    end

    assign freq_est = freq_q;
`else
    assign freq_est = 8'h00;
`endif

    assign period_out = period_q;
    assign high_out   = high_q;
    assign max_out    = max_q;
    assign min_out    = min_q;
    assign meas_vld   = vld_q;
    assign timeout    = to_q;
endmodule

// File: tb/tb_square_wave_meas.sv
// Directed bench for square_wave_meas: vector table of square waves plus hand-written corner sequences.
module tb_square_wave_meas;
    localparam int CNT_W = 24;
    localparam int TO    = 2000;
`ifdef SQW_MEAS_FREQ_EST_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       sample_in = 8'h00;
    logic             sample_vld = 1'b0;
    logic             meas_clr = 1'b0;
    logic [CNT_W-1:0] period_out, high_out;
    logic [7:0]       max_out, min_out, freq_est;
    logic             meas_vld, timeout;

    always #5 clk = ~clk;

    square_wave_meas #(
        .TH_HI(8'd192), .TH_LO(8'd160), .CNT_W(CNT_W), .TIMEOUT(24'(TO))
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_vld(sample_vld),
        .meas_clr(meas_clr), .period_out(period_out), .high_out(high_out),
        .max_out(max_out), .min_out(min_out), .meas_vld(meas_vld),
        .timeout(timeout), .freq_est(freq_est)
    );

    typedef struct {
        logic [7:0] hi; int hl; logic [7:0] lo; int ll; int n;
        int period; int high; int mx; int mn; int npulse; int freq;
    } vec_t;

    vec_t vecs[4];
    int   checks = 0, errors = 0, pulses = 0;
    bit   gap = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] s, input logic v, input logic c);
        sample_in  = s;
        sample_vld = v;
        meas_clr   = c;
        @(posedge clk);
        #1;
        if (meas_vld) pulses++;
        meas_clr = 1'b0;
    endtask

    // One valid sample; with gap set, an invalid cycle carrying a contrary level follows.
    task automatic put(input logic [7:0] s, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            step(s, 1'b1, 1'b0);
            if (gap) step(~s, 1'b0, 1'b0);
        end
    endtask

    task automatic clr();
        step(8'h00, 1'b0, 1'b1);
        pulses = 0;
    endtask

    task automatic run_wave(input vec_t v);
        put(v.lo, v.ll);
        for (int c = 0; c < v.n; c++) begin
            put(v.hi, v.hl);
            put(v.lo, v.ll);
        end
        put(v.hi, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " period"},  int'(period_out), 0);
        check({tag, " high"},    int'(high_out), 0);
        check({tag, " max"},     int'(max_out), 0);
        check({tag, " min"},     int'(min_out), 255);
        check({tag, " vld"},     int'(meas_vld), 0);
        check({tag, " timeout"}, int'(timeout), 0);
        check({tag, " freq"},    int'(freq_est), 0);
    endtask

    initial begin
        vecs[0] = '{8'd255, 1025, 8'd128, 1025, 2, 2050, 1025, 255, 128, 2, 1};
        vecs[1] = '{8'd200, 10,   8'd100, 30,   3, 40,   10,   200, 100, 3, 0};
        vecs[2] = '{8'd192, 5,    8'd160, 7,    2, 12,   5,    192, 160, 2, 0};
        vecs[3] = '{8'd255, 1,    8'd0,   1,    4, 2,    1,    255, 0,   4, 0};

        #12;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            clr();
            run_wave(vecs[k]);
            check($sformatf("v%0d period", k), int'(period_out), vecs[k].period);
            check($sformatf("v%0d high", k),   int'(high_out), vecs[k].high);
            check($sformatf("v%0d max", k),    int'(max_out), vecs[k].mx);
            check($sformatf("v%0d min", k),    int'(min_out), vecs[k].mn);
            check($sformatf("v%0d pulses", k), pulses, vecs[k].npulse);
            check($sformatf("v%0d freq", k),   int'(freq_est), FEN ? vecs[k].freq : 0);
        end

        // Hysteresis: 180 inside the low phase must not register as an edge.
        clr();
        put(8'd100, 3);
        for (int c = 0; c < 3; c++) begin
            put(8'd200, 10);
            for (int i = 0; i < 30; i++) put((i % 6 == 2) ? 8'd180 : 8'd100, 1);
        end
        put(8'd200, 1);
        check("hyst period", int'(period_out), 40);
        check("hyst high",   int'(high_out), 10);
        check("hyst max",    int'(max_out), 200);
        check("hyst min",    int'(min_out), 100);
        check("hyst pulses", pulses, 3);

        // Stream starting high is ignored until a low level arms the FSM.
        clr();
        put(8'd255, 20);
        put(8'd100, 10);
        put(8'd200, 10);
        check("starthi pulses early", pulses, 0);
        put(8'd100, 10);
        put(8'd200, 1);
        check("starthi pulses", pulses, 1);
        check("starthi period", int'(period_out), 20);
        check("starthi high",   int'(high_out), 10);

        // Timeout: arming sample, then TO samples in ARMED.
        clr();
        put(8'd128, TO);
        check("timeout before", int'(timeout), 0);
        put(8'd128, 1);
        check("timeout set", int'(timeout), 1);
        put(8'd200, 5);
        put(8'd100, 5);
        put(8'd200, 5);
        put(8'd100, 5);
        put(8'd200, 1);
        check("post-timeout pulses", pulses, 1);
        check("post-timeout period", int'(period_out), 10);
        check("timeout sticky", int'(timeout), 1);
        clr();
        check("timeout cleared", int'(timeout), 0);
        check("clr period", int'(period_out), 0);

        // meas_clr wins over a publishing rising-edge sample.
        clr();
        put(8'd100, 3);
        put(8'd200, 5);
        put(8'd100, 5);
        put(8'd200, 5);
        check("pre-clr period", int'(period_out), 10);
        put(8'd100, 5);
        pulses = 0;
        step(8'd200, 1'b1, 1'b1);
        check("clr+rise vld", int'(meas_vld), 0);
        check("clr+rise period", int'(period_out), 0);
        check("clr+rise min", int'(min_out), 255);
        put(8'd200, 3);
        check("clr+rise pulses", pulses, 0);

        // Asynchronous reset mid-period.
        clr();
        run_wave(vecs[1]);
        put(8'd100, 5);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("mid-reset");
        #1 rst_n = 1'b1;

        // sample_vld toggled: invalid cycles must not count.
        clr();
        gap = 1'b1;
        run_wave(vecs[0]);
        gap = 1'b0;
        check("gap period", int'(period_out), 2050);
        check("gap high",   int'(high_out), 1025);
        check("gap pulses", pulses, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
